// File: rtl/seg_scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_pkg
// Shared constants for the multiplexed 7-segment scan decoder and the display
// driver that produces the scan:
//   - active-low segment codes for digits 0-9 and blank (bit7=a ... bit1=g,
//     bit0=dp; dp is always written as 1 (off) here)
//   - active-low one-hot digit select codes
//   - decoded value codes BLANK / BAD
//   - FSM state type and small helpers for classifying a digit select code
// -----------------------------------------------------------------------------
package seg_scan_decoder_pkg;

  // Segment patterns, active low, dp off
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  // Digit select codes, active-low one-hot; digit3 is the leftmost
  localparam logic [3:0] DIG_SEL_3 = 4'b0111;
  localparam logic [3:0] DIG_SEL_2 = 4'b1011;
  localparam logic [3:0] DIG_SEL_1 = 4'b1101;
  localparam logic [3:0] DIG_SEL_0 = 4'b1110;
  localparam logic [3:0] DIG_NONE  = 4'b1111;

  // Decoded value codes beyond BCD
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] BAD   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // True when exactly one digit is being driven
  function automatic logic dig_is_sel(input logic [3:0] dig);
    return (dig == DIG_SEL_3) || (dig == DIG_SEL_2) ||
           (dig == DIG_SEL_1) || (dig == DIG_SEL_0);
  endfunction

  // True when more than one digit line is driven low at once
  function automatic logic dig_multi_low(input logic [3:0] dig);
    return ($countones(~dig) > 1);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational lookup of an active-low 7-segment pattern to its digit
// value. The decimal point is ignored.
//   seg   in  8  active-low segments (bit7=a ... bit1=g, bit0=dp)
//   value out 4  0-9 for digits, BLANK for all-off, BAD for anything else
// -----------------------------------------------------------------------------
module seg7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] value
);

  logic [7:0] seg_m;

  always_comb begin
    // Force dp to "off" so a lit decimal point still matches its digit
    seg_m = seg | 8'h01;
    value = BAD;
    case (seg_m)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = BLANK;
      default:   value = BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Snoops a 4-digit multiplexed 7-segment display bus and recovers the shown
// digits. Each digit is captured once its segment/select lines have been
// stable for SETTLE_CYC cycles; when all four digits have been captured the
// frame is published on 'digits'.
//
// Parameters
//   SETTLE_CYC   consecutive identical samples needed for a capture (>= 2)
//   TIMEOUT_CYC  cycles without a capture before the scan is declared lost
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   seg_in[7:0]  active-low segments, asynchronous
//   dig_in[3:0]  active-low one-hot digit select, asynchronous
//   digits[15:0] last complete frame, [15:12]=digit3 ... [3:0]=digit0
//   frame_valid  one-cycle pulse when digits updates
//   scan_active  high while captures keep arriving within TIMEOUT_CYC
//   seg_err      one-cycle pulse after capturing an undecodable pattern
//   dig_err      one-cycle pulse on entry into a multi-low select code
// -----------------------------------------------------------------------------
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  dig_in,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        scan_active,
  output logic        seg_err,
  output logic        dig_err
);

  localparam int unsigned SC_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  // Two-flop synchronizers plus a one-cycle history for change detection
  logic [7:0] seg_s1_q, seg_s2_q, seg_prev_q;
  logic [3:0] dig_s1_q, dig_s2_q, dig_prev_q;

  scan_state_e state_q, state_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0][3:0]   staging_q, staging_d;
  logic [3:0]        mask_q, mask_d, mask_base;
  logic [15:0]       digits_q, digits_d;
  logic              frame_valid_q, frame_valid_d;
  logic              scan_active_q, scan_active_d;
  logic              seg_err_q, seg_err_d;
  logic              dig_err_q, dig_err_d;
  logic              multi_low_prev_q, multi_low_d;

  logic              dig_sel;
  logic              changed;
  logic              capture;
  logic              to_sat;
  logic [3:0]        dec_value;
  logic [1:0]        dig_idx;

  seg7_decode u_seg7_decode (
    .seg   (seg_s2_q),
    .value (dec_value)
  );

  always_comb begin
    dig_sel     = dig_is_sel(dig_s2_q);
    multi_low_d = dig_multi_low(dig_s2_q);
    changed     = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q);
    dig_idx     = 2'd0;
    case (dig_s2_q)
      DIG_SEL_3: dig_idx = 2'd3;
      DIG_SEL_2: dig_idx = 2'd2;
      DIG_SEL_1: dig_idx = 2'd1;
      default:   dig_idx = 2'd0;
    endcase
  end

  // Capture FSM
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dig_sel) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SC_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!dig_sel) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (changed) begin
          settle_cnt_d = SC_W'(1);
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_d == SC_W'(SETTLE_CYC)) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Holding the captured digit; only a change may arm a new capture
        if (!dig_sel) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (changed) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SC_W'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  // Frame assembly, timeout and flags
  always_comb begin
    staging_d = staging_q;
    if (capture) begin
      staging_d[dig_idx] = dec_value;
    end

    to_sat   = (to_cnt_q == TO_W'(TIMEOUT_CYC));
    to_cnt_d = to_cnt_q;
    if (capture) begin
      to_cnt_d = '0;
    end else if (!to_sat) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    scan_active_d = scan_active_q;
    if (capture) begin
      scan_active_d = 1'b1;
    end else if (to_sat) begin
      scan_active_d = 1'b0;
    end

    // A completed frame is published one cycle after the mask fills; a
    // capture landing in that same cycle starts the next frame's mask.
    frame_valid_d = (mask_q == 4'hF);
    digits_d      = frame_valid_d ? staging_q : digits_q;
    mask_base     = (frame_valid_d || to_sat) ? 4'h0 : mask_q;
    mask_d        = capture ? (mask_base | ~dig_s2_q) : mask_base;

    seg_err_d = capture && (dec_value == BAD);
    dig_err_d = multi_low_d && !multi_low_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_s1_q         <= 8'hFF;
      seg_s2_q         <= 8'hFF;
      seg_prev_q       <= 8'hFF;
      dig_s1_q         <= 4'hF;
      dig_s2_q         <= 4'hF;
      dig_prev_q       <= 4'hF;
      state_q          <= ST_IDLE;
      settle_cnt_q     <= '0;
      to_cnt_q         <= '0;
      staging_q        <= {4{BLANK}};
      mask_q           <= 4'h0;
      digits_q         <= {4{BLANK}};
      frame_valid_q    <= 1'b0;
      scan_active_q    <= 1'b0;
      seg_err_q        <= 1'b0;
      dig_err_q        <= 1'b0;
      multi_low_prev_q <= 1'b0;
    end else begin
      seg_s1_q         <= seg_in;
      seg_s2_q         <= seg_s1_q;
      seg_prev_q       <= seg_s2_q;
      dig_s1_q         <= dig_in;
      dig_s2_q         <= dig_s1_q;
      dig_prev_q       <= dig_s2_q;
      state_q          <= multi_low_d ? ST_IDLE : state_d;
      settle_cnt_q     <= settle_cnt_d;
      to_cnt_q         <= to_cnt_d;
      staging_q        <= staging_d;
      mask_q           <= mask_d;
      digits_q         <= digits_d;
      frame_valid_q    <= frame_valid_d;
      scan_active_q    <= scan_active_d;
      seg_err_q        <= seg_err_d;
      dig_err_q        <= dig_err_d;
      multi_low_prev_q <= multi_low_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign scan_active = scan_active_q;
  assign seg_err     = seg_err_q;
  assign dig_err     = dig_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Directed scans of the display bus with hand-computed expected frames.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  dig_in = 4'hF;
  logic [15:0] digits;
  logic        frame_valid, scan_active, seg_err, dig_err;

  always #10 clk = ~clk;

  seg_scan_decoder #(
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .dig_in      (dig_in),
    .digits      (digits),
    .frame_valid (frame_valid),
    .scan_active (scan_active),
    .seg_err     (seg_err),
    .dig_err     (dig_err)
  );

  // Active-low segment codes for 0..9, dp off
  logic [7:0] seg_code [0:9];
  initial begin
    seg_code[0] = 8'b0000_0011; seg_code[1] = 8'b1001_1111;
    seg_code[2] = 8'b0010_0101; seg_code[3] = 8'b0000_1101;
    seg_code[4] = 8'b1001_1001; seg_code[5] = 8'b0100_1001;
    seg_code[6] = 8'b0100_0001; seg_code[7] = 8'b0001_1111;
    seg_code[8] = 8'b0000_0001; seg_code[9] = 8'b0000_1001;
  end

  int n_vec  = 0;
  int n_miss = 0;
  int fv_cnt = 0, se_cnt = 0, de_cnt = 0;

  // Count high cycles of each pulse output
  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (seg_err)     se_cnt <= se_cnt + 1;
    if (dig_err)     de_cnt <= de_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic show_raw(input logic [3:0] dig, input logic [7:0] seg, input int cycles);
    dig_in = dig;
    seg_in = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic show(input int d, input int v, input int cycles);
    logic [3:0] one;
    one = 4'b0001 << d;
    show_raw(~one, seg_code[v], cycles);
  endtask

  int fv0, se0, de0, lat;

  initial begin
    // ---- reset state
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_digits",      32'(digits),      32'hFFFF);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_scan_active", 32'(scan_active), 32'h0);
    chk("rst_seg_err",     32'(seg_err),     32'h0);
    chk("rst_dig_err",     32'(dig_err),     32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // ---- basic frame 1,2,3,4
    fv0 = fv_cnt;
    show(3, 1, 50); show(2, 2, 50); show(1, 3, 50); show(0, 4, 50);
    chk("basic_frames",      32'(fv_cnt - fv0), 32'd1);
    chk("basic_digits",      32'(digits),       32'h1234);
    chk("basic_scan_active", 32'(scan_active),  32'h1);

    // ---- glitching last digit: no capture until the final pattern settles
    fv0 = fv_cnt;
    show(3, 5, 50); show(2, 6, 50); show(1, 7, 50);
    for (int k = 0; k < 8; k++) show(0, (k % 2 == 0) ? 1 : 2, 5);
    chk("glitch_no_early_frame", 32'(fv_cnt - fv0), 32'd0);
    seg_in = seg_code[9];
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        lat = i;
        break;
      end
    end
    // 2 sync + SETTLE stable cycles to capture, then one cycle to publish
    chk("glitch_latency", 32'(lat), 32'(SETTLE + 3));
    repeat (30) @(negedge clk);
    chk("glitch_frames", 32'(fv_cnt - fv0), 32'd1);
    chk("glitch_digits", 32'(digits),       32'h5679);

    // ---- undecodable pattern on digit1
    fv0 = fv_cnt; se0 = se_cnt;
    show(3, 2, 50); show(2, 0, 50);
    show_raw(4'b1101, 8'b1111_0000, 50);
    show(0, 8, 50);
    chk("bad_seg_err_pulses", 32'(se_cnt - se0), 32'd1);
    chk("bad_frames",         32'(fv_cnt - fv0), 32'd1);
    chk("bad_digits",         32'(digits),       32'h20E8);

    // ---- invalid digit select between digits
    fv0 = fv_cnt; de0 = de_cnt;
    show(3, 4, 50); show(2, 3, 50);
    show_raw(4'b0011, seg_code[3], 30);
    chk("dig_err_pulses", 32'(de_cnt - de0), 32'd1);
    chk("dig_err_no_frame", 32'(fv_cnt - fv0), 32'd0);
    show(1, 2, 50); show(0, 1, 50);
    chk("dig_err_frames", 32'(fv_cnt - fv0), 32'd1);
    chk("dig_err_digits", 32'(digits),       32'h4321);

    // ---- scan stalls after 3 digits, then resumes starting from digit0
    fv0 = fv_cnt;
    show(3, 3, 50); show(2, 2, 50); show(1, 1, 50);
    chk("stall_active_before", 32'(scan_active), 32'h1);
    show_raw(4'hF, 8'hFF, 1100);
    chk("stall_scan_active", 32'(scan_active),  32'h0);
    chk("stall_no_frame",    32'(fv_cnt - fv0), 32'd0);
    chk("stall_digits_kept", 32'(digits),       32'h4321);
    show(0, 6, 50);
    chk("resume_no_stale_frame", 32'(fv_cnt - fv0), 32'd0);
    show(3, 9, 50); show(2, 8, 50); show(1, 7, 50);
    chk("resume_frames",      32'(fv_cnt - fv0), 32'd1);
    chk("resume_digits",      32'(digits),       32'h9876);
    chk("resume_scan_active", 32'(scan_active),  32'h1);

    // ---- reset mid-frame discards the partial frame
    show(3, 1, 50); show(2, 2, 50);
    show_raw(4'hF, 8'hFF, 5);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_digits",      32'(digits),      32'hFFFF);
    chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
    chk("midrst_scan_active", 32'(scan_active), 32'h0);
    chk("midrst_seg_err",     32'(seg_err),     32'h0);
    chk("midrst_dig_err",     32'(dig_err),     32'h0);
    reset = 1'b1;
    @(negedge clk);
    fv0 = fv_cnt;
    show(1, 3, 50); show(0, 2, 50);
    chk("midrst_no_partial_frame", 32'(fv_cnt - fv0), 32'd0);
    show(3, 5, 50); show(2, 4, 50);
    chk("midrst_frames", 32'(fv_cnt - fv0), 32'd1);
    chk("midrst_digits", 32'(digits),       32'h5432);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYC, default 16: consecutive identical synchronized samples required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYC, default 200000: cycles without any capture before the scan is declared lost.
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 seg_in  in  8  active-low segments; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; asynchronous to clk.
REQ-006 dig_in  in  4  active-low one-hot digit select; 4'b0111=digit3 (leftmost), 4'b1011=digit2, 4'b1101=digit1, 4'b1110=digit0; asynchronous.
REQ-007 digits  out  16  last complete frame; [15:12]=digit3 ... [3:0]=digit0; BCD 0-9, 4'hF=blank, 4'hE=undecodable.
REQ-008 frame_valid  out  1  one-cycle pulse when digits updates.
REQ-009 scan_active  out  1  high while captures arrive within TIMEOUT_CYC of each other.
REQ-010 seg_err  out  1  one-cycle pulse on capture of an undecodable pattern.
REQ-011 dig_err  out  1  one-cycle pulse when synchronized dig_in has more than one bit low.

Function
REQ-012 seg_in and dig_in pass through a two-flop synchronizer; all logic below uses synchronized values.
REQ-013 Decode table, seg (7:0) -> value: 00000011->0, 10011111->1, 00100101->2, 00001101->3, 10011001->4, 01001001->5, 01000001->6, 00011111->7, 00000001->8, 00001001->9, 11111111->F; dp bit ignored for matching (bit0 masked to 1); any other pattern -> E.
REQ-014 States: IDLE (dig all-high or invalid), SETTLE (valid dig, counting), HOLD (captured, waiting for change).
REQ-015 IDLE->SETTLE when dig is valid one-hot; stability counter loads 1.
REQ-016 SETTLE: counter increments each cycle that {seg,dig} equals the previous cycle; any change reloads counter to 1 (stays SETTLE if dig valid, else IDLE).
REQ-017 SETTLE->HOLD when counter reaches SETTLE_CYC; in that cycle the decoded value is written to the staging slot for the selected digit and its mask bit set.
REQ-018 HOLD->SETTLE on any change of {seg,dig} with valid dig; HOLD->IDLE on dig all-high or invalid; no second capture without a change.
REQ-019 Recapture of a digit already in the mask overwrites its staging slot; no error.
REQ-020 When the mask becomes 4'b1111, on the next cycle digits <= staging, frame_valid=1, mask cleared; a capture in that same cycle sets its mask bit in the new frame.
REQ-021 seg_err pulses the cycle after a capture decoding to E; value E is still stored.
REQ-022 dig_err pulses once per entry into an invalid dig code (rising detection), state forced to IDLE.
REQ-023 Timeout counter resets to 0 on every capture, saturates at TIMEOUT_CYC; at saturation scan_active=0 and mask cleared; scan_active=1 again on next capture.
REQ-024 Capture latency: 2 sync cycles + SETTLE_CYC cycles from a stable input change.

Reset
REQ-025 While reset=0 at a clk edge: state=IDLE, counters=0, mask=0, staging=all 4'hF, synchronizers=all-ones.
REQ-026 Reset outputs: digits=16'hFFFF, frame_valid=0, scan_active=0, seg_err=0, dig_err=0.
REQ-027 Reset mid-frame discards partial staging; no frame_valid issued for it.

Structure
REQ-028 Shared package holds the ten segment code constants, the blank code, the four dig select codes, and value constants BLANK=4'hF, BAD=4'hE, shared with the display driver.
REQ-029 One combinational sub-module seg7_decode (8-bit pattern -> 4-bit value) implements REQ-013; instantiated once.

Verification
REQ-030 Scan 1,2,3,4 on digit3..0, each held 50 cycles, SETTLE_CYC=16 -> frame_valid one pulse, digits=16'h1234, scan_active=1.
REQ-031 Digit glitch: pattern toggled every 5 cycles for 40 cycles then held -> exactly one capture, only after final pattern stable 16 cycles.
REQ-032 Pattern 8'b11110000 on digit1 within a frame -> seg_err one pulse; frame digits nibble [7:4]=4'hE.
REQ-033 dig_in=4'b0011 for 30 cycles -> one dig_err pulse, no capture, state IDLE.
REQ-034 Scan stops after 3 digits for TIMEOUT_CYC (set 1000) -> scan_active=0, no frame_valid; resumed full scan of 9,8,7,6 -> digits=16'h9876.
REQ-035 reset=0 for one cycle after 2 captures -> digits=16'hFFFF, all flags 0; next full scan produces single correct frame.
